// File: rtl/victim_cache_fill_ctrl_pkg.sv
// rtl/victim_cache_fill_ctrl_pkg.sv - victim cache geometry and fill FSM state encoding
package cache_def;

    localparam int INDEX_VC     = 4;
    localparam int INDEX_WAY_VC = 3;
    localparam int DEPTH_VC     = 2 ** INDEX_VC;
    localparam int NUM_WAYS_VC  = 2 ** INDEX_WAY_VC;

    typedef enum logic [2:0] {
        VC_IDLE    = 3'd0,
        VC_SELECT  = 3'd1,
        VC_READ    = 3'd2,
        VC_WB      = 3'd3,
        VC_INSTALL = 3'd4
    } vc_fill_state_e;

endpackage

// File: rtl/victim_cache_fill_ctrl_invalid_way_pe.sv
// rtl/victim_cache_fill_ctrl_invalid_way_pe.sv - lowest invalid way priority encoder
module vc_invalid_way_pe
    import cache_def::*;
(
    input  logic [NUM_WAYS_VC-1:0]  valid,
    output logic [INDEX_WAY_VC-1:0] way,
    output logic                    any_invalid
);

    // Scan from the top down so the lowest-numbered invalid way is written last and wins.
    always_comb begin
        way         = '0;
        any_invalid = 1'b0;
        for (int i = NUM_WAYS_VC - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                way         = INDEX_WAY_VC'(i);
                any_invalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/victim_cache_fill_ctrl.sv
// rtl/victim_cache_fill_ctrl.sv - victim cache fill/eviction sequencer (option: VC_PREFER_INVALID_EN)
module victim_cache_fill_ctrl
    import cache_def::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ins_valid_i,
    output logic                    ins_ready_o,
    input  logic [INDEX_VC-1:0]     ins_index_i,
    input  logic                    ins_dirty_i,
    input  logic [INDEX_WAY_VC-1:0] plru_way_i,
    output logic [INDEX_VC-1:0]     plru_index_o,
    output logic                    plru_valid_o,
    output logic [INDEX_WAY_VC-1:0] plru_way_o,
    input  logic                    hit_inval_i,
    input  logic [INDEX_VC-1:0]     hit_index_i,
    input  logic [INDEX_WAY_VC-1:0] hit_way_i,
    output logic                    arr_rd_o,
    output logic                    arr_wr_o,
    output logic [INDEX_VC-1:0]     arr_index_o,
    output logic [INDEX_WAY_VC-1:0] arr_way_o,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic                    busy_o
);

    vc_fill_state_e state_q, state_d;

    logic [INDEX_VC-1:0]     idx_q;
    logic                    dirty_q;
    logic [INDEX_WAY_VC-1:0] victim_q;
    logic [INDEX_WAY_VC-1:0] victim_sel;

    logic [NUM_WAYS_VC-1:0]  valid_q [DEPTH_VC];
    logic [NUM_WAYS_VC-1:0]  dirty_arr_q [DEPTH_VC];

    logic [NUM_WAYS_VC-1:0]  set_valid;
    logic [NUM_WAYS_VC-1:0]  set_dirty;
    logic [INDEX_WAY_VC-1:0] pe_way;
    logic                    pe_any_invalid;

    // Selection reads the registered state, so a same-cycle invalidation is not yet visible.
    assign set_valid = valid_q[idx_q];
    assign set_dirty = dirty_arr_q[idx_q];

    vc_invalid_way_pe u_invalid_way_pe (
        .valid       (set_valid),
        .way         (pe_way),
        .any_invalid (pe_any_invalid)
    );

`ifdef VC_PREFER_INVALID_EN
    assign victim_sel = pe_any_invalid ? pe_way : plru_way_i;
`else
    logic unused_pe;
    assign unused_pe  = ^{pe_way, pe_any_invalid};
    assign victim_sel = plru_way_i;
`endif

    // State register; reset from any state abandons the operation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= VC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request on acceptance and the victim way at the end of SELECT.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_q    <= '0;
            dirty_q  <= 1'b0;
            victim_q <= '0;
        end else begin
            if (state_q == VC_IDLE && ins_valid_i) begin
                idx_q   <= ins_index_i;
                dirty_q <= ins_dirty_i;
            end
            if (state_q == VC_SELECT) begin
                victim_q <= victim_sel;
            end
        end
    end

    // Per-set valid/dirty; the install is applied after the invalidation so it wins a collision.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < DEPTH_VC; s++) begin
                valid_q[s]     <= '0;
                dirty_arr_q[s] <= '0;
            end
        end else begin
            if (hit_inval_i) begin
                valid_q[hit_index_i][hit_way_i]     <= 1'b0;
                dirty_arr_q[hit_index_i][hit_way_i] <= 1'b0;
            end
            if (state_q == VC_INSTALL) begin
                valid_q[idx_q][victim_q]     <= 1'b1;
                dirty_arr_q[idx_q][victim_q] <= dirty_q;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        ins_ready_o  = 1'b0;
        plru_index_o = idx_q;
        plru_valid_o = 1'b0;
        plru_way_o   = '0;
        arr_rd_o     = 1'b0;
        arr_wr_o     = 1'b0;
        arr_index_o  = '0;
        arr_way_o    = '0;
        wb_valid_o   = 1'b0;
        busy_o       = (state_q != VC_IDLE);
        case (state_q)
            VC_IDLE: begin
                ins_ready_o  = rst_ni;
                plru_index_o = ins_index_i;
                if (ins_valid_i) begin
                    state_d = VC_SELECT;
                end
            end
            VC_SELECT: begin
                if (set_valid[victim_sel] && set_dirty[victim_sel]) begin
                    state_d = VC_READ;
                end else begin
                    state_d = VC_INSTALL;
                end
            end
            VC_READ: begin
                arr_rd_o    = 1'b1;
                arr_index_o = idx_q;
                arr_way_o   = victim_q;
                state_d     = VC_WB;
            end
            VC_WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    state_d = VC_INSTALL;
                end
            end
            VC_INSTALL: begin
                arr_wr_o     = 1'b1;
                arr_index_o  = idx_q;
                arr_way_o    = victim_q;
                plru_valid_o = 1'b1;
                plru_way_o   = victim_q;
                state_d      = VC_IDLE;
            end
            default: begin
                state_d = VC_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_victim_cache_fill_ctrl.sv
// tb/tb_victim_cache_fill_ctrl.sv - scoreboard bench for victim_cache_fill_ctrl (tracks VC_PREFER_INVALID_EN)
module tb_victim_cache_fill_ctrl;
    import cache_def::*;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    ins_valid_i;
    logic                    ins_ready_o;
    logic [INDEX_VC-1:0]     ins_index_i;
    logic                    ins_dirty_i;
    logic [INDEX_WAY_VC-1:0] plru_way_i;
    logic [INDEX_VC-1:0]     plru_index_o;
    logic                    plru_valid_o;
    logic [INDEX_WAY_VC-1:0] plru_way_o;
    logic                    hit_inval_i;
    logic [INDEX_VC-1:0]     hit_index_i;
    logic [INDEX_WAY_VC-1:0] hit_way_i;
    logic                    arr_rd_o;
    logic                    arr_wr_o;
    logic [INDEX_VC-1:0]     arr_index_o;
    logic [INDEX_WAY_VC-1:0] arr_way_o;
    logic                    wb_valid_o;
    logic                    wb_ready_i;
    logic                    busy_o;

    always #5 clk_i = ~clk_i;

    victim_cache_fill_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ins_valid_i  (ins_valid_i),
        .ins_ready_o  (ins_ready_o),
        .ins_index_i  (ins_index_i),
        .ins_dirty_i  (ins_dirty_i),
        .plru_way_i   (plru_way_i),
        .plru_index_o (plru_index_o),
        .plru_valid_o (plru_valid_o),
        .plru_way_o   (plru_way_o),
        .hit_inval_i  (hit_inval_i),
        .hit_index_i  (hit_index_i),
        .hit_way_i    (hit_way_i),
        .arr_rd_o     (arr_rd_o),
        .arr_wr_o     (arr_wr_o),
        .arr_index_o  (arr_index_o),
        .arr_way_o    (arr_way_o),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .busy_o       (busy_o)
    );

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // kind 0 = array read of the victim, kind 1 = install write
    typedef struct {
        int kind;
        int idx;
        int way;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    bit m_valid [DEPTH_VC][NUM_WAYS_VC];
    bit m_dirty [DEPTH_VC][NUM_WAYS_VC];

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < DEPTH_VC; s++)
            for (int w = 0; w < NUM_WAYS_VC; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
    endfunction

    function automatic int model_victim(int idx, int plru);
`ifdef VC_PREFER_INVALID_EN
        for (int w = 0; w < NUM_WAYS_VC; w++)
            if (!m_valid[idx][w]) return w;
`endif
        return plru;
    endfunction

    // Monitor: every array operation must match the oldest expectation, on time.
    always @(negedge clk_i) begin
        if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_op: kind %0d set %0d way %0d due cycle %0d, now %0d",
                     sbq[0].kind, sbq[0].idx, sbq[0].way, sbq[0].cyc, cyc);
            void'(sbq.pop_front());
        end
        if (rst_ni && (arr_rd_o || arr_wr_o)) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_op: rd %0d wr %0d set %0d way %0d cycle %0d",
                         arr_rd_o, arr_wr_o, arr_index_o, arr_way_o, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("op_kind", int'(arr_wr_o), mon_e.kind);
                chk("op_rd_excl", int'(arr_rd_o & arr_wr_o), 0);
                chk("op_index", int'(arr_index_o), mon_e.idx);
                chk("op_way", int'(arr_way_o), mon_e.way);
                chk("op_cycle", cyc, mon_e.cyc);
                if (arr_wr_o) begin
                    chk("plru_valid", int'(plru_valid_o), 1);
                    chk("plru_way", int'(plru_way_o), mon_e.way);
                    chk("plru_index", int'(plru_index_o), mon_e.idx);
                end
            end
        end else if (rst_ni && plru_valid_o) begin
            chk("plru_valid_stray", int'(plru_valid_o), 0);
        end
    end

    task automatic hit_pulse(int idx, int way);
        hit_inval_i = 1'b1;
        hit_index_i = INDEX_VC'(idx);
        hit_way_i   = INDEX_WAY_VC'(way);
        @(negedge clk_i);
        hit_inval_i = 1'b0;
        m_valid[idx][way] = 1'b0;
        m_dirty[idx][way] = 1'b0;
    endtask

    // One request from IDLE. hit_mode: 0 none, 1 invalidate victim during INSTALL,
    // 2 invalidate victim in the first WB cycle. rst_in_wb aborts during WB.
    task automatic do_op(int idx, bit dirty, int plru, int d, int hit_mode, bit rst_in_wb);
        int k;
        int v;
        bit wbp;
        int inst;
        v   = model_victim(idx, plru);
        wbp = m_valid[idx][v] && m_dirty[idx][v];
        ins_valid_i = 1'b1;
        ins_index_i = INDEX_VC'(idx);
        ins_dirty_i = dirty;
        plru_way_i  = INDEX_WAY_VC'(plru);
        k = cyc;
        chk("ins_ready_accept", int'(ins_ready_o), 1);
        if (wbp) begin
            sbq.push_back('{0, idx, v, k + 2});
            inst = k + 4 + d;
        end else begin
            inst = k + 2;
        end
        if (!(wbp && rst_in_wb)) sbq.push_back('{1, idx, v, inst});
        @(negedge clk_i);
        ins_valid_i = 1'b0;
        chk("busy_select", int'(busy_o), 1);
        if (wbp) begin
            while (cyc < k + 3) @(negedge clk_i);
            if (rst_in_wb) begin
                chk("wb_valid_pre_rst", int'(wb_valid_o), 1);
                @(negedge clk_i);
                chk("wb_valid_pre_rst2", int'(wb_valid_o), 1);
                rst_ni = 1'b0;
                @(negedge clk_i);
                chk("rst_wb_valid", int'(wb_valid_o), 0);
                chk("rst_busy", int'(busy_o), 0);
                chk("rst_arr_wr", int'(arr_wr_o), 0);
                chk("rst_ins_ready", int'(ins_ready_o), 0);
                model_reset();
                @(negedge clk_i);
                rst_ni = 1'b1;
                @(negedge clk_i);
                chk("rst_release_ready", int'(ins_ready_o), 1);
                return;
            end
            for (int j = 0; j <= d; j++) begin
                chk("wb_valid_held", int'(wb_valid_o), 1);
                if (j == 0 && hit_mode == 2) begin
                    hit_inval_i = 1'b1;
                    hit_index_i = INDEX_VC'(idx);
                    hit_way_i   = INDEX_WAY_VC'(v);
                end
                if (j == d) wb_ready_i = 1'b1;
                @(negedge clk_i);
                wb_ready_i  = 1'b0;
                hit_inval_i = 1'b0;
            end
            chk("wb_valid_drop", int'(wb_valid_o), 0);
        end else begin
            @(negedge clk_i);
            chk("no_wb_valid", int'(wb_valid_o), 0);
        end
        if (hit_mode == 1) begin
            hit_inval_i = 1'b1;
            hit_index_i = INDEX_VC'(idx);
            hit_way_i   = INDEX_WAY_VC'(v);
        end
        @(negedge clk_i);
        hit_inval_i = 1'b0;
        chk("ready_after", int'(ins_ready_o), 1);
        chk("busy_after", int'(busy_o), 0);
        m_valid[idx][v] = 1'b1;
        m_dirty[idx][v] = dirty;
    endtask

    initial begin
        rst_ni      = 1'b0;
        ins_valid_i = 1'b0;
        ins_index_i = '0;
        ins_dirty_i = 1'b0;
        plru_way_i  = '0;
        hit_inval_i = 1'b0;
        hit_index_i = '0;
        hit_way_i   = '0;
        wb_ready_i  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("reset_ins_ready", int'(ins_ready_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_wb_valid", int'(wb_valid_o), 0);
        chk("reset_arr_rd", int'(arr_rd_o), 0);
        chk("reset_arr_wr", int'(arr_wr_o), 0);
        chk("reset_plru_valid", int'(plru_valid_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("release_ins_ready", int'(ins_ready_o), 1);

        do_op(2, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < NUM_WAYS_VC; i++) do_op(1, 1'b1, i, 0, 0, 1'b0);
        do_op(1, 1'b0, 5, 3, 0, 1'b0);
        do_op(1, 1'b1, 5, 0, 0, 1'b0);
        hit_pulse(1, 3);
        do_op(1, 1'b1, 6, 0, 0, 1'b0);
        do_op(1, 1'b1, 0, 2, 0, 1'b1);
        do_op(1, 1'b1, 4, 0, 0, 1'b0);
        do_op(2, 1'b1, 1, 0, 1, 1'b0);
        do_op(2, 1'b1, 1, 1, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0)
                hit_pulse($urandom_range(0, 3), $urandom_range(0, NUM_WAYS_VC - 1));
            do_op($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, NUM_WAYS_VC - 1), $urandom_range(0, 3),
                  $urandom_range(0, 2), 1'b0);
        end

        repeat (3) @(negedge clk_i);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
